// File: rtl/s386_resp_capture.sv
`timescale 1ns/1ps
// Response-capture stage for the s386 core: windowed sampling into a valid/ready FIFO.
// Optional 16-bit MISR compaction when RESP_MISR_EN is defined; otherwise signature reads 0.
module s386_resp_capture #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WINDOW = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [6:0]               resp_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              signature
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WIN_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   after_pop_c;
    logic               valid_q, valid_d;
    logic [6:0]         data_q, data_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [6:0]         mem_q [DEPTH];

    logic pop_c, sample_c, push_c, start_c;

    assign pop_c    = valid_q && out_ready;
    assign sample_c = (state_q == RUN);
    assign start_c  = (state_q != RUN) && start;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push_c   = sample_c && ((count_q < CNT_W'(DEPTH)) || pop_c);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    win_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                win_d = win_q + WIN_W'(1);
                if (!push_c) ovf_d = 1'b1;
                if (win_q == WIN_W'(WINDOW - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_comb begin
        rd_d        = rd_q + PTR_W'(pop_c);
        wr_d        = wr_q + PTR_W'(push_c);
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        after_pop_c = count_q - CNT_W'(pop_c);
        valid_d     = (count_d != '0);
        data_d      = data_q;
        // Head register holds the word at rd_d after this edge; a push into an empty FIFO lands there directly.
        if (after_pop_c != '0)
            data_d = mem_q[rd_d];
        else if (push_c)
            data_d = resp_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Storage array carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_q] <= resp_in;
    end

`ifdef RESP_MISR_EN
    logic [15:0] sig_q, sig_d;
    logic        fb_c;

    assign fb_c = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

    always_comb begin
        sig_d = sig_q;
        if (start_c)
            sig_d = 16'hFFFF;
        else if (sample_c)
            sig_d = {sig_q[14:0], fb_c} ^ {9'b0, resp_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= 16'hFFFF;
        else        sig_q <= sig_d;
    end

    assign signature = sig_q;
`else
    logic unused_start_c;
    assign unused_start_c = start_c;
    assign signature      = 16'h0000;
`endif

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_s386_resp_capture.sv
`timescale 1ns/1ps
// Bench for s386_resp_capture: directed phases plus random traffic against a queue-based model.
module tb_s386_resp_capture;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WINDOW = 64;
`ifdef RESP_MISR_EN
    localparam bit MISR_EN = 1'b1;
`else
    localparam bit MISR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  resp_in;
    logic        out_ready;
    logic        out_valid;
    logic [6:0]  out_data;
    logic [3:0]  count;
    logic        overflow, busy, done;
    logic [15:0] signature;

    logic        w1_start;
    logic [6:0]  w1_resp;
    logic        w1_ready;
    logic        w1_valid;
    logic [6:0]  w1_data;
    logic [3:0]  w1_count;
    logic        w1_ovf, w1_busy, w1_done;
    logic [15:0] w1_sig;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int         m_st;      // 0 idle, 1 run, 2 done
    int         m_n;
    bit         m_ovf;
    logic [15:0] m_sig;
    logic [6:0] q[$];
    logic [6:0] got[$];

    always #5 clk = ~clk;

    s386_resp_capture #(.DEPTH(DEPTH), .WINDOW(WINDOW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .resp_in(resp_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow), .busy(busy), .done(done),
        .signature(signature)
    );

    s386_resp_capture #(.DEPTH(DEPTH), .WINDOW(1)) u_w1 (
        .clk(clk), .reset(reset), .start(w1_start), .resp_in(w1_resp),
        .out_valid(w1_valid), .out_ready(w1_ready), .out_data(w1_data),
        .count(w1_count), .overflow(w1_ovf), .busy(w1_busy), .done(w1_done),
        .signature(w1_sig)
    );

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [6:0] r);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ {9'b0, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_n = 0; m_ovf = 1'b0; m_sig = 16'hFFFF;
        q.delete();
    endtask

    task automatic check_all();
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        if (q.size() != 0) chk("data", 32'(out_data), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(m_st == 1));
        chk("done", 32'(done), 32'(m_st == 2));
        chk("signature", 32'(signature), MISR_EN ? 32'(m_sig) : 32'h0);
    endtask

    // One clock of stimulus followed by model update and full output check.
    task automatic cyc(input logic st, input logic [6:0] r, input logic rdy);
        bit pop, push;
        @(negedge clk);
        start = st; resp_in = r; out_ready = rdy;
        #1;
        if (out_valid && rdy) got.push_back(out_data);
        @(posedge clk);
        pop = (q.size() != 0) && rdy;
        if (m_st == 1) begin
            push  = (q.size() < DEPTH) || pop;
            m_sig = misr(m_sig, r);
            m_n++;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(r);
            else      m_ovf = 1'b1;
            if (m_n == WINDOW) m_st = 2;
        end else begin
            if (pop) void'(q.pop_front());
            if (st) begin
                m_st = 1; m_n = 0; m_sig = 16'hFFFF; m_ovf = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; resp_in = '0; out_ready = 1'b0;
        w1_start = 1'b0; w1_resp = '0; w1_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_data", 32'(out_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // idle with start low
        for (int i = 0; i < 20; i++) cyc(1'b0, 7'(i), 1'b0);

        // window-of-one MISR on second instance
        w1_start = 1'b1; w1_resp = 7'h7F;
        cyc(1'b0, 7'h0, 1'b0);
        chk("w1_busy", 32'(w1_busy), 32'h1);
        chk("w1_done0", 32'(w1_done), 32'h0);
        w1_start = 1'b0;
        cyc(1'b0, 7'h0, 1'b0);
        chk("w1_done", 32'(w1_done), 32'h1);
        chk("w1_sig7f", 32'(w1_sig), MISR_EN ? 32'hFF81 : 32'h0);
        w1_start = 1'b1; w1_resp = 7'h00;
        cyc(1'b0, 7'h0, 1'b0);
        w1_start = 1'b0;
        cyc(1'b0, 7'h0, 1'b0);
        chk("w1_done2", 32'(w1_done), 32'h1);
        chk("w1_sig00", 32'(w1_sig), MISR_EN ? 32'hFFFE : 32'h0);
        w1_ready = 1'b1;
        cyc(1'b0, 7'h0, 1'b0);
        cyc(1'b0, 7'h0, 1'b0);
        chk("w1_drained", 32'(w1_count), 32'h0);

        // streaming with consumer always ready
        got.delete();
        cyc(1'b1, 7'h0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 7'(i), 1'b1);
            chk("stream_cnt_le1", 32'(count <= 4'd1), 32'h1);
        end
        cyc(1'b0, 7'h0, 1'b1);
        cyc(1'b0, 7'h0, 1'b1);
        chk("stream_nwords", 32'(got.size()), 32'd64);
        for (int i = 0; i < 64 && i < got.size(); i++) chk("stream_word", 32'(got[i]), 32'(i));
        chk("stream_ovf", 32'(overflow), 32'h0);

        // fill, push+pop at full, then overflow
        got.delete();
        cyc(1'b1, 7'h0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 7'(i), (i == 8));
            if (i == 7) chk("full_cnt", 32'(count), 32'd8);
            if (i == 8) begin
                chk("pp_cnt", 32'(count), 32'd8);
                chk("pp_ovf", 32'(overflow), 32'h0);
                chk("pp_head", 32'(out_data), 32'd1);
            end
        end
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_cnt", 32'(count), 32'd8);
        got.delete();
        for (int i = 0; i < 12; i++) cyc(1'b0, 7'h0, 1'b1);
        chk("drain_n", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("drain_word", 32'(got[i]), 32'(i + 1));
        cyc(1'b1, 7'h0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'h0);

        // abort mid-window with asynchronous reset
        for (int i = 0; i < 30; i++) cyc(1'b0, 7'(i), 1'($urandom_range(0, 1)));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_data", 32'(out_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        got.delete();
        cyc(1'b1, 7'h0, 1'b1);
        for (int i = 0; i < 64; i++) cyc(1'b0, 7'(i) ^ 7'h55, 1'b1);
        cyc(1'b0, 7'h0, 1'b1);
        cyc(1'b0, 7'h0, 1'b1);
        chk("post_rst_n", 32'(got.size()), 32'd64);
        for (int i = 0; i < 64 && i < got.size(); i++) chk("post_rst_word", 32'(got[i]), 32'(7'(i) ^ 7'h55));

        // random traffic
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 15) == 0), 7'($urandom), 1'($urandom_range(0, 2) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/s386_resp_capture.md
# s386_resp_capture

Downstream response-capture stage for the s386 sequential core: samples the core's 7-bit primary-output vector every clock during a programmed capture window. It buffers each sample in a small FIFO that test logic drains over a valid/ready port, and optionally compacts the window into a 16-bit MISR signature for locked/unlocked response comparison.

## Interface
- DEPTH, 8, FIFO depth in words; power of two, ≥2
- WINDOW, 64, samples per capture window; 1..65535
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a capture window
- resp_in  in  7  core outputs, bit6=v13_D_12 … bit0=v13_D_6
- out_valid  out  1  FIFO head word available
- out_ready  in  1  consumer accepts head word
- out_data  out  7  FIFO head word
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a sample was dropped because FIFO full
- busy  out  1  state == RUN
- done  out  1  state == DONE
- signature  out  16  MISR value

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → RUN; window counter ← 0, MISR ← 16'hFFFF, overflow ← 0.
- RUN: every cycle samples resp_in (1 sample/cycle, no gaps); counter increments; after sample number WINDOW is taken → DONE. start ignored in RUN.
- DONE: signature frozen; FIFO still drains. start=1 → RUN with the same initialisation as from IDLE; FIFO contents retained.
- Push: sample written to FIFO if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle; otherwise sample dropped and overflow ← 1. Overflow stays set until the next start.
- Pop: out_valid && out_ready; head advances, count decrements. Push+pop in the same cycle leaves count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty derived from count.
- MISR (on every sampled cycle, including dropped samples): fb = s[15]^s[14]^s[12]^s[3]; s ← {s[14:0], fb} ^ {9'b0, resp_in}.
- out_data valid only while out_valid=1; contents are don't-care when empty.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, overflow=0, busy=0, done=0, signature=16'hFFFF; FIFO pointers 0; state IDLE.
- Reset asserted mid-window: immediately returns all of the above; buffered words discarded.
- start high in cycle t (IDLE/DONE) → busy=1 in t+1; first sample taken at the end of t+1; last sample at the end of t+WINDOW; done=1 in t+WINDOW+1.
- Sample-to-out_valid latency: 1 cycle (no empty-FIFO bypass).
- count, overflow, and signature reflect the edge on which they were updated (registered outputs).
- out_valid stays asserted with stable out_data until popped.

## Configuration
- RESP_MISR_EN defined: MISR logic present; signature behaves as above.
- RESP_MISR_EN undefined: no MISR register; signature tied to 16'h0000 at all times; FSM, FIFO, and overflow unchanged.

## Test plan
- Reset/idle: release reset, hold start=0 for 20 cycles → out_valid=0, count=0, busy=0, done=0, signature=16'hFFFF.
- Single-sample MISR: WINDOW=1, start, resp_in=7'h7F → done after 2 cycles, signature=16'hFF81. Repeat with resp_in=7'h00 → 16'hFFFE. Without RESP_MISR_EN → 16'h0000.
- Streaming: WINDOW=64, DEPTH=8, out_ready=1, resp_in = incrementing 0..63 → 64 words out in order, overflow=0, count ≤1 throughout.
- Overflow: WINDOW=12, out_ready=0 → count saturates at 8; words 0..7 retained; overflow=1. Drain → exactly 8 words. Next start clears overflow.
- Full boundary push+pop: FIFO full with out_ready pulsed high in the same cycle as a sample → count stays 8, overflow stays 0, head advances by one.
- Reset mid-window: assert reset at sample 30 of 64 → all outputs return to reset values asynchronously. A following start runs a full 64-sample window with correct data.
